// File: rtl/shift_register_burst.sv
// Shift register with manual shift, parallel load, selectable shift modes
// and a counted burst engine reporting busy/done.
module shift_register_burst #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             direction,
    input  logic [1:0]       mode,
    input  logic             in,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] MODE_LOG  = 2'b00;
    localparam logic [1:0] MODE_ROT  = 2'b01;
    localparam logic [1:0] MODE_ARI  = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             dir_q;
    logic [1:0]       mode_q;

    // One shift position; fill is the bit entering the vacated end.
    function automatic logic [WIDTH-1:0] step_fn(
        input logic [WIDTH-1:0] d,
        input logic             dr,
        input logic [1:0]       m,
        input logic             b
    );
        logic fill;
        fill = b;
        if (m == MODE_HOLD) begin
            return d;
        end
        if (m == MODE_ROT) begin
            fill = dr ? d[0] : d[WIDTH-1];
        end else if (m == MODE_ARI && dr) begin
            fill = d[WIDTH-1];
        end else if (m == MODE_LOG) begin
            fill = b;
        end
        return dr ? {fill, d[WIDTH-1:1]} : {d[WIDTH-2:0], fill};
    endfunction

    assign out = direction ? parallel_out[0] : parallel_out[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            parallel_out <= '0;
            state        <= IDLE;
            cnt          <= '0;
            dir_q        <= 1'b0;
            mode_q       <= MODE_LOG;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                parallel_out <= parallel_in;
                state        <= IDLE;
                cnt          <= '0;
                busy         <= 1'b0;
            end else if (state == BURST) begin
                if (en) begin
                    parallel_out <= step_fn(parallel_out, dir_q, mode_q, in);
                    cnt          <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
            end else if (start) begin
                if (count != '0) begin
                    cnt    <= count;
                    dir_q  <= direction;
                    mode_q <= mode;
                    state  <= BURST;
                    busy   <= 1'b1;
                end else begin
                    done <= 1'b1;
                end
            end else if (en) begin
                parallel_out <= step_fn(parallel_out, direction, mode, in);
            end
        end
    end

endmodule

// File: tb/tb_shift_register_burst.sv
// Randomised and directed bench for shift_register_burst against a
// behavioural model of the shift/burst rules.
module tb_shift_register_burst;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] parallel_in = 8'h00;
    logic       direction = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       in = 1'b0;
    logic       start = 1'b0;
    logic [3:0] count = 4'd0;
    logic [7:0] parallel_out;
    logic       out;
    logic       busy;
    logic       done;

    int total = 0;
    int bad = 0;
    bit chk = 1'b0;

    shift_register_burst #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .parallel_in(parallel_in), .direction(direction), .mode(mode),
        .in(in), .start(start), .count(count),
        .parallel_out(parallel_out), .out(out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Model state
    logic [7:0] md;
    bit         mbusy, mdone, mdir;
    logic [1:0] mmode;
    int         rem;

    function automatic logic [7:0] mshift(logic [7:0] d, bit dr,
                                          logic [1:0] m, bit b);
        int v;
        v = d;
        case (m)
            2'd0: v = dr ? (v >> 1) | (b << 7) : ((v << 1) | b) & 255;
            2'd1: v = dr ? (v >> 1) | ((v & 1) << 7)
                         : ((v << 1) | (v >> 7)) & 255;
            2'd2: v = dr ? (v >> 1) | (v & 128) : ((v << 1) | b) & 255;
            default: v = d;
        endcase
        return v[7:0];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            md = 8'h00; mbusy = 0; mdone = 0; rem = 0;
        end else begin
            mdone = 0;
            if (load) begin
                md = parallel_in; mbusy = 0; rem = 0;
            end else if (mbusy) begin
                if (en) begin
                    md = mshift(md, mdir, mmode, in);
                    rem = rem - 1;
                    if (rem == 0) begin
                        mbusy = 0; mdone = 1;
                    end
                end
            end else if (start) begin
                if (count > 0) begin
                    rem = count; mbusy = 1; mdir = direction; mmode = mode;
                end else begin
                    mdone = 1;
                end
            end else if (en) begin
                md = mshift(md, direction, mode, in);
            end
        end
    end

    task automatic check(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            check("model_pout", parallel_out, md);
            check("model_busy", busy, mbusy);
            check("model_done", done, mdone);
            check("model_out", out, direction ? md[0] : md[7]);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_load(logic [7:0] v);
        load = 1; parallel_in = v; tick(); load = 0;
    endtask

    task automatic burst(bit dr, logic [1:0] m, logic [3:0] n, bit b,
                         int stall_at, int stall_len, bit ign,
                         output int bcyc);
        int i;
        direction = dr; mode = m; count = n; in = b;
        start = 1; en = 1; tick(); start = 0;
        i = 0; bcyc = 0;
        while (busy && i < 100) begin
            bcyc++;
            en = !(i >= stall_at && i < stall_at + stall_len);
            start = ign && (i == 1);
            tick();
            i++;
        end
        en = 0; start = 0;
        if (i >= 100) check("burst_timeout", i, 0);
    endtask

    initial begin
        int bc;
        // Reset with noisy inputs
        rst = 1; en = 1; in = 1; start = 1;
        repeat (3) tick();
        chk = 1;
        check("rst_pout", parallel_out, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out", out, 0);
        check("rst_model", md, 8'h00);
        rst = 0; en = 0; in = 0; start = 0;
        tick();

        do_load(8'hA5);
        check("load_pout", parallel_out, 8'hA5);
        direction = 0; #1 check("load_out_d0", out, 1);
        direction = 1; #1 check("load_out_d1", out, 1);

        burst(0, 2'b00, 3, 1, 99, 0, 0, bc);
        check("log_pout", parallel_out, 8'h2F);
        check("log_model", md, 8'h2F);
        check("log_busy_cycles", bc, 3);
        check("log_done", done, 1);
        tick();
        check("log_done_pulse", done, 0);
        check("log_hold_idle", parallel_out, 8'h2F);

        do_load(8'h96);
        burst(1, 2'b10, 4, 0, 99, 0, 0, bc);
        check("ari_pout", parallel_out, 8'hF9);
        check("ari_model", md, 8'hF9);

        do_load(8'h81);
        burst(1, 2'b01, 3, 1, 99, 0, 0, bc);
        check("rot_r3", parallel_out, 8'h30);

        do_load(8'h81);
        burst(0, 2'b01, 8, 0, 99, 0, 0, bc);
        check("rot_l8", parallel_out, 8'h81);
        check("rot_l8_cycles", bc, 8);

        // Stall plus ignored start during the burst
        do_load(8'hA5);
        burst(0, 2'b00, 2, 1, 1, 3, 1, bc);
        check("stall_cycles", bc, 5);
        check("stall_pout", parallel_out, 8'h97);
        check("stall_done", done, 1);
        tick();
        check("stall_done_pulse", done, 0);
        check("stall_no_restart", busy, 0);

        // Back-to-back: restart in the done cycle
        do_load(8'h01);
        burst(0, 2'b00, 1, 0, 99, 0, 0, bc);
        direction = 0; count = 1; start = 1; tick(); start = 0;
        check("b2b_busy", busy, 1);
        en = 1; tick(); en = 0;
        check("b2b_pout", parallel_out, 8'h04);
        check("b2b_done", done, 1);

        // Abort by load
        do_load(8'h5A);
        direction = 0; mode = 0; count = 5; start = 1; en = 1;
        tick(); start = 0; tick(); tick();
        load = 1; parallel_in = 8'h3C; tick(); load = 0; en = 0;
        check("abort_pout", parallel_out, 8'h3C);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        tick();
        check("abort_done2", done, 0);

        // Zero count
        count = 0; start = 1; tick(); start = 0;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_pout", parallel_out, 8'h3C);
        tick();
        check("zero_done2", done, 0);

        // Reset mid-burst
        count = 6; start = 1; en = 1; tick(); start = 0; tick();
        rst = 1; tick(); rst = 0; en = 0;
        check("midrst_pout", parallel_out, 8'h00);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);

        // Random traffic, checked every cycle by the compare process
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            load = ($urandom_range(0, 9) == 0);
            parallel_in = 8'($urandom);
            start = ($urandom_range(0, 6) == 0);
            count = 4'($urandom);
            en = ($urandom_range(0, 9) < 7);
            in = 1'($urandom);
            direction = 1'($urandom);
            mode = 2'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_register_burst.md
# shift_register_burst

Parametrised successor to the team's single-step shift register. It keeps the manual per-cycle shift and parallel load, and adds selectable shift modes (logical, rotate, arithmetic) and a counted burst engine. The burst engine shifts N positions on request and reports busy/done. It sits between the serial links and the parallel datapath, for use as a serialiser/deserialiser or as a multi-position shifter.

## Interface
Parameters:
- WIDTH, 8, register width in bits (>= 2)
- CNT_W, 4, width of burst count; must satisfy 2^CNT_W - 1 >= WIDTH

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset: one clock; reset is synchronous and active-high
- en  input  1  shift enable; manual shift when idle, stall control when busy
- load  input  1  parallel load request
- parallel_in  input  WIDTH  load data
- direction  input  1  0 = shift toward MSB (new bit enters [0]); 1 = shift toward LSB (new bit enters [WIDTH-1])
- mode  input  2  00 logical, 01 rotate, 10 arithmetic, 11 hold (no shift)
- in  input  1  serial input bit
- start  input  1  burst request
- count  input  CNT_W  number of positions to shift in the burst
- parallel_out  output  WIDTH  register contents
- out  output  1  serial output: parallel_out[WIDTH-1] when direction=0, parallel_out[0] when direction=1; combinational from the register and the live direction
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse at burst completion

## Operation
- FSM states: IDLE, BURST.
- Priority at each edge: rst > load > burst step > start > manual shift.
- rst: parallel_out=0, busy=0, done=0, counter=0, state=IDLE. Applies mid-burst with no done pulse.
- load: parallel_out<=parallel_in in any state. In BURST it aborts the burst: go to IDLE, busy=0, no done. Any start in the same cycle is ignored.
- Shift step, using dir and mode:
  - logical: shifts, with `in` inserted at the vacated end.
  - rotate: the bit leaving wraps to the vacated end; `in` is ignored.
  - arithmetic: with dir=1, [WIDTH-1] is replicated and `in` is ignored. With dir=0, it behaves as logical.
  - hold: parallel_out is unchanged, but the step still counts in BURST.
- IDLE, start=1, count>0: latch count, direction and mode. Go to BURST, busy=1. No shift on this edge.
- IDLE, start=1, count=0: stay in IDLE, done=1 for the next cycle, no shift.
- IDLE, start=0, en=1, no load: one shift using the live direction and mode (legacy behaviour).
- BURST: on each edge with en=1, do one step using the latched dir/mode and the live `in`, and decrement the counter. On the step where the counter goes 1->0, go to IDLE, busy=0, done=1 for one cycle. With en=0, hold everything (stall).
- start while in BURST is ignored. count > WIDTH is legal (rotate wraps; logical/arithmetic saturate the fill).
- done is 0 in every cycle other than the single completion cycle.

## Timing
- Load latency: 1 edge. parallel_out equals parallel_in right after the edge where load=1.
- Burst with en held high, start sampled at edge k, count=N:
  - busy=1 from edge k through edge k+N.
  - Shifts happen at edges k+1..k+N.
  - done=1 in the cycle after edge k+N.
  - busy=0 and done=1 in the same cycle.
- Each en=0 cycle during BURST extends busy by exactly one cycle.
- A new start is accepted in the cycle where done=1; back-to-back bursts have one idle edge between them.
- `out` follows the register and direction with zero latency.

## Test plan
- Reset: hold rst=1 for 3 edges with en=1, in=1, start=1 -> parallel_out=0x00, busy=0, done=0, out=0.
- Load: load=1 with parallel_in=0xA5 -> 0xA5 after one edge; out=1 with direction=0, out=1 with direction=1.
- Logical burst: from 0xA5, mode=00, dir=0, in=1, count=3 -> 0x2F; busy high exactly 3 cycles after start; done a single pulse.
- Arithmetic/rotate:
  - 0x96 with mode=10, dir=1, count=4 -> 0xF9.
  - 0x81 with mode=01, dir=1, count=3 -> 0x30.
  - 0x81 with mode=01, dir=0, count=8 -> 0x81.
- Stall and ignore: burst count=2 with en=0 for 3 cycles mid-burst -> busy lasts 5 cycles, result identical to the unstalled run. A start pulse during BURST changes nothing.
- Abort and corner cases:
  - load=0x3C mid-burst -> 0x3C, busy=0, no done.
  - start with count=0 -> one done pulse, parallel_out unchanged.
  - rst mid-burst -> all outputs 0 on the next edge.
